vga_timing: RTL
===============

# vga_timing

VGA timing generator and output stage for the parallax video path. It generates the 640x480 pixel raster coordinates consumed by the parallax renderer. It accepts the renderer's pipelined RGB back and drives the pad-level `hsync`, `vsync` and `rgb` signals, with sync delayed to stay aligned with renderer latency. Default timing is 832 x 520 dots per frame (640x480@72, 31.5 MHz pixel clock).

## Interface

Parameters:
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP`, 24: horizontal front porch, in clocks.
- `H_SYNC`, 40: horizontal sync width, in clocks.
- `H_BP`, 128: horizontal back porch, in clocks.
- `V_FP`, 9: vertical front porch, in lines.
- `V_SYNC`, 3: vertical sync width, in lines.
- `V_BP`, 28: vertical back porch, in lines.
- `V_ACTIVE`, 480: visible lines.
- `SYNC_POL`, 0: asserted level of `hsync`/`vsync`; 0 means active-low.
- `PIPE_DELAY`, 2: renderer latency in clocks, legal range 0..7.

Ports:
- `clk` in 1: pixel clock.
- `reset` in 1: synchronous, active-low reset.
- `rgb_in` in 3: renderer pixel for the coordinates presented `PIPE_DELAY` clocks earlier.
- `x` out 10: horizontal counter, 0..831.
- `y` out 10: visible line index, 0..479; 0 outside visible lines.
- `active` out 1: current counter position is visible.
- `line_start` out 1: high for one clock when hcount==0.
- `frame_start` out 1: high for one clock when hcount==0 and vcount==0.
- `hsync` out 1: pad horizontal sync.
- `vsync` out 1: pad vertical sync.
- `rgb` out 3: pad colour, blanked outside the visible area.

## Operation

Counters:
- `hcount` wraps from 0 to 831 (H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP).
- `vcount` wraps from 0 to 519 (V_TOTAL); it increments only when `hcount` wraps from 831 to 0.
- `vcount` wraps to 0 when it is 519 and `hcount` wraps.

Horizontal regions, by `hcount`:
- 0..639: active.
- 640..663: front porch.
- 664..703: sync.
- 704..831: back porch.

Vertical regions, by `vcount` (blanking comes first in the frame):
- 0..8: front porch.
- 9..11: sync.
- 12..39: back porch.
- 40..519: active.

Decoded outputs (combinational from counter registers, zero latency):
- `x` = hcount.
- `active` = (hcount < H_ACTIVE) && (vcount >= V_FP+V_SYNC+V_BP).
- `y` = vcount − 40 on visible lines, otherwise 0.
- `line_start` and `frame_start` as defined in the port list.

Raw sync terms, computed from the counter state:
- `hs_raw` = hcount in sync region.
- `vs_raw` = vcount in sync region.
- `vs_raw` is a whole-line quantity and changes only at hcount==0.

Delay pipeline:
- `hs_raw`, `vs_raw` and `active` pass through a shift register of `PIPE_DELAY` stages.
- The shift register is followed by one output register.

Output register:
- `hsync` = SYNC_POL ? hs_d : ~hs_d.
- `vsync` = SYNC_POL ? vs_d : ~vs_d.
- `rgb` = active_d ? rgb_in : 3'b000.

Width rules:
- Counters are 10 bits, with no overflow at the defaults.
- `y` subtraction is performed only inside the visible region.

## Timing

Latency:
- Counter state at clock n appears on `hsync`/`vsync` at the rising edge ending clock n+PIPE_DELAY.
- `rgb_in` sampled in clock n+PIPE_DELAY, gated by the matching `active_d`, appears registered one edge later.
- `x`, `y`, `active`, `line_start` and `frame_start` have no latency relative to the counters.

Reset (`reset`==0 at a rising edge):
- hcount = 0, vcount = 0.
- All pipeline stages are loaded with inactive values (hs=0, vs=0, active=0).
- `hsync` and `vsync` take the deasserted level, which is 1 for SYNC_POL=0.
- `rgb` = 0.
- `x` = 0, `y` = 0, `active` = 0.
- `line_start` and `frame_start` are held at 0 while `reset` is low.

First cycle after reset release:
- hcount = 0 and vcount = 0, so `line_start` = 1 and `frame_start` = 1.
- The frame begins in the vertical front porch.

Reset mid-frame:
- Takes effect at the next edge, with no partial-line completion.
- Stale pipeline contents are discarded; no visible pixel leaks.

Sync shape:
- `hsync` is asserted for exactly H_SYNC consecutive clocks per line; period is 832.
- `vsync` is asserted for exactly 3×832 clocks per frame; period is 432640.

Simultaneous events:
- At the wrap from hcount 831 / vcount 519, both counters reset in the same edge.
- `frame_start` implies `line_start`.

`rgb_in` is ignored whenever the delayed `active` is 0.

## Test plan

- **Reset values:** hold `reset`=0 for 10 clocks mid-run → `hsync`=1, `vsync`=1, `rgb`=0, `x`=0, `y`=0, `active`=0 throughout. On release, `frame_start`=1 in the first clock, and `hsync` stays 1 for 664+PIPE_DELAY+1 edges.
- **Horizontal timing** (defaults) → each `hsync` low pulse is exactly 40 clocks and pulse starts are 832 clocks apart. The first falling edge follows `line_start` by 664+PIPE_DELAY+1 clocks.
- **Vertical timing** → after `frame_start`, `vsync` is high for 9 lines, low for exactly 3 lines (2496 clocks), then high. `active` first rises at line 40 and `frame_start` recurs every 432640 clocks.
- **Blanking:** drive `rgb_in`=3'b111 constantly → `rgb`=7 on exactly 640×480 = 307200 clocks per frame, with zero non-blank `rgb` while `hsync` or `vsync` is asserted.
- **Alignment:** a model renderer outputs `rgb_in`={x[0], y[0], 1}, delayed by PIPE_DELAY, for PIPE_DELAY = 0, 2 and 7 → the first visible `rgb` of each line is 3'b0y1 and alternates every clock. There is no pixel at hcount 640.
- **Reset mid-active:** assert `reset` at vcount 200, hcount 300 with `rgb_in`=7 → `rgb` is 0 from the next edge. After release, the next frame restarts at vcount 0 with correct porch counts.

Source files
------------

// File: rtl/vga_timing.sv
// VGA raster timing generator and pad output stage.
// Counts dots and lines, decodes raster coordinates for the renderer, and
// registers hsync/vsync/rgb with sync delayed to match renderer latency.
module vga_timing #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 24,
  parameter int H_SYNC     = 40,
  parameter int H_BP       = 128,
  parameter int V_FP       = 9,
  parameter int V_SYNC     = 3,
  parameter int V_BP       = 28,
  parameter int V_ACTIVE   = 480,
  parameter int SYNC_POL   = 0,
  parameter int PIPE_DELAY = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] rgb_in,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       active,
  output logic       line_start,
  output logic       frame_start,
  output logic       hsync,
  output logic       vsync,
  output logic [2:0] rgb
);

  localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_LAST     = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_FP);
  localparam logic [9:0] V_SYNC_END = 10'(V_FP + V_SYNC);
  localparam logic [9:0] V_ACT_BEG  = 10'(V_FP + V_SYNC + V_BP);
  localparam logic [9:0] V_LAST     = 10'(V_FP + V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic       POL        = (SYNC_POL != 0);

  logic [9:0] hcount_q, hcount_d;
  logic [9:0] vcount_q, vcount_d;
  logic       v_vis;
  logic       hs_raw, vs_raw;
  logic       hs_dly, vs_dly, act_dly;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic [2:0] rgb_q, rgb_d;

  // Dot counter wraps every line; line counter advances on the dot wrap
  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (!reset) begin
      hcount_d = 10'd0;
      vcount_d = 10'd0;
    end else if (hcount_q == H_LAST) begin
      hcount_d = 10'd0;
      vcount_d = (vcount_q == V_LAST) ? 10'd0 : vcount_q + 10'd1;
    end else begin
      hcount_d = hcount_q + 10'd1;
    end
  end

  // Counter state registers
  always_ff @(posedge clk) begin
    hcount_q <= hcount_d;
    vcount_q <= vcount_d;
  end

  // Zero-latency coordinate decode; vertical blanking sits at the top of the frame
  always_comb begin
    v_vis       = (vcount_q >= V_ACT_BEG);
    x           = hcount_q;
    y           = v_vis ? (vcount_q - V_ACT_BEG) : 10'd0;
    active      = (hcount_q < H_ACT_END) && v_vis;
    line_start  = reset && (hcount_q == 10'd0);
    frame_start = reset && (hcount_q == 10'd0) && (vcount_q == 10'd0);
    hs_raw      = (hcount_q >= H_SYNC_BEG) && (hcount_q < H_SYNC_END);
    vs_raw      = (vcount_q >= V_SYNC_BEG) && (vcount_q < V_SYNC_END);
  end

  generate
    if (PIPE_DELAY == 0) begin : g_no_pipe
      assign hs_dly  = hs_raw;
      assign vs_dly  = vs_raw;
      assign act_dly = active;
    end else begin : g_pipe
      logic [2:0] sr_q [PIPE_DELAY];
      logic [2:0] sr_d [PIPE_DELAY];

      // Shift {hs, vs, active} one stage per clock; reset flushes stale state
      always_comb begin
        for (int i = 0; i < PIPE_DELAY; i++) sr_d[i] = 3'b000;
        if (reset) begin
          sr_d[0] = {hs_raw, vs_raw, active};
          for (int i = 1; i < PIPE_DELAY; i++) sr_d[i] = sr_q[i-1];
        end
      end

      // Delay-line stage registers
      always_ff @(posedge clk) begin
        for (int i = 0; i < PIPE_DELAY; i++) sr_q[i] <= sr_d[i];
      end

      assign {hs_dly, vs_dly, act_dly} = sr_q[PIPE_DELAY-1];
    end
  endgenerate

  // Pad values: apply sync polarity and blank colour outside the delayed visible area
  always_comb begin
    hsync_d = POL ? hs_dly : ~hs_dly;
    vsync_d = POL ? vs_dly : ~vs_dly;
    rgb_d   = act_dly ? rgb_in : 3'b000;
    if (!reset) begin
      hsync_d = ~POL;
      vsync_d = ~POL;
      rgb_d   = 3'b000;
    end
  end

  // Pad output register
  always_ff @(posedge clk) begin
    hsync_q <= hsync_d;
    vsync_q <= vsync_d;
    rgb_q   <= rgb_d;
  end

  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign rgb   = rgb_q;

endmodule
